seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The module SHALL have parameter N_DIGITS, default 4, giving the number of multiplexed 7-segment digits (range 1..8).
REQ-002 The module SHALL have parameter REFRESH_DIV, default 25000, giving the clk cycles per digit slot (minimum 2).
REQ-003 The module SHALL have parameter BLINK_SLOTS, default 256, giving the digit slots per blink half-period (minimum 1).
REQ-004 The module SHALL have port clk, input, 1 bit: system clock.
REQ-005 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port enable, input, 1 bit: display on when high.
REQ-007 The module SHALL have port load, input, 1 bit: single-cycle strobe that latches codes, dp_mask and blink_mask.
REQ-008 The module SHALL have port codes, input, N_DIGITS*5 bits: per-digit character code, with digit i at bits [5i+4:5i].
REQ-009 The module SHALL have port dp_mask, input, N_DIGITS bits: decimal point per digit.
REQ-010 The module SHALL have port blink_mask, input, N_DIGITS bits: blink per digit.
REQ-011 The module SHALL have port seg, output, 8 bits, registered: segment pattern {a,b,c,d,e,f,g,dp}, active-high.
REQ-012 The module SHALL have port an, output, N_DIGITS bits, registered: digit anodes, active-low, one-hot-low.

Function
REQ-013 The shadow code, dp and blink registers SHALL update only on clk edges where load=1; the input ports are ignored at all other times.
REQ-014 The refresh counter SHALL count 0..REFRESH_DIV-1, then wrap to 0.
REQ-015 Each wrap of the refresh counter SHALL generate a one-cycle slot tick.
REQ-016 On each slot tick, the digit index SHALL advance by one, and SHALL wrap from N_DIGITS-1 to 0.
REQ-017 an SHALL drive bit[index]=0 and all other bits 1 in the cycle after the index updates, giving a latency of 1 cycle.
REQ-018 seg SHALL be updated in the same cycle as an, from the shadow registers of the new index.
REQ-019 Code decode for seg[7:1] SHALL follow these patterns:
- 0-9 and A-F (10-15): standard hex patterns, e.g. 0=1111110, 1=0110000, 8=1111111, A=1110111, C=1001110.
- 16: T=1110000.
- 17: J=0111000.
- 18: dash=0000001.
- 19-31: blank=0000000.
REQ-020 seg[0] SHALL equal dp_mask[index] (shadow value).
REQ-021 When load coincides with a slot tick, the newly loaded values SHALL appear at the next output update, one cycle later; no torn or mixed pattern SHALL be output.
REQ-022 When enable=0, an SHALL be all ones and seg SHALL be 0 from the next cycle, and the refresh counter, index and blink counters SHALL hold.
REQ-023 When enable returns to 1, scanning SHALL resume from the held index.
REQ-024 The counter widths SHALL be $clog2 of their range, and the counters SHALL never exceed their terminal values.

Reset
REQ-025 Asserting rst_n low SHALL immediately set:
- an to all ones;
- seg, the refresh counter, the index, the blink slot counter, blink_phase, the dp shadow and the blink shadow to 0;
- every code shadow to 19 (blank).
REQ-026 A reset asserted mid-slot SHALL abort the slot, and scanning SHALL restart at index 0 with a full REFRESH_DIV slot after release.

Configuration
REQ-027 The macro SEG_SCAN_BLINK_EN, when defined, SHALL compile in the blink function described in REQ-028 and REQ-029.
REQ-028 With SEG_SCAN_BLINK_EN defined, a blink slot counter SHALL count slot ticks 0..BLINK_SLOTS-1, and blink_phase SHALL toggle on its wrap.
REQ-029 With SEG_SCAN_BLINK_EN defined, seg SHALL be forced to 0 for any digit with blink_mask=1 while blink_phase=1; an SHALL be unaffected.
REQ-030 With SEG_SCAN_BLINK_EN undefined, the blink counter and blink shadow logic SHALL be absent, and blink_mask SHALL be ignored.

Verification
REQ-031 The bench SHALL cover reset with REFRESH_DIV=4 and N_DIGITS=4: rst_n low -> an=4'b1111 and seg=0; after release and enable=1 -> an=1110 first, then 1101, 1011, 0111, 1110, each for 4 cycles.
REQ-032 The bench SHALL cover decode: load codes={17,16,10,0} with dp_mask=0001 -> digit0 seg=11111101, digit1 seg=11101110, digit2 seg=11100000, digit3 seg=01110000.
REQ-033 The bench SHALL cover load on the slot-tick cycle: the new codes appear at the following output update, with no mixed pattern.
REQ-034 The bench SHALL cover enable: enable=0 for 10 cycles mid-slot -> an all ones and seg=0; on re-enable, the same index resumes with its remaining slot count.
REQ-035 The bench SHALL cover blink with SEG_SCAN_BLINK_EN defined and BLINK_SLOTS=2: blink_mask=0010 and code 8 -> digit1 seg alternates 11111110/0 every 2 slots, while the other digits stay steady.
REQ-036 The bench SHALL cover blink with SEG_SCAN_BLINK_EN undefined: the same stimulus as REQ-035 -> digit1 stays 11111110.

Source files
------------

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: latches per-digit codes on load and drives one active-low anode per slot.
// Optional blink support is compiled in with the SEG_SCAN_BLINK_EN macro.
module seg_scan_display #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 25000,
  parameter int BLINK_SLOTS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [N_DIGITS*5-1:0]   codes,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic [N_DIGITS-1:0]     blink_mask,
  output logic [7:0]              seg,
  output logic [N_DIGITS-1:0]     an
);

  localparam int                CNT_W      = $clog2(REFRESH_DIV);
  localparam int                IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [4:0]        CODE_BLANK = 5'd19;

  // Shadow registers: the only place the input ports are sampled.
  logic [4:0]          code_q [N_DIGITS];
  logic [N_DIGITS-1:0] dp_q;

  // Scan state.
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tick;

  // Registered outputs.
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  // NOTE: the shadow array is reset because a blank code must be displayed
  // before the first load; otherwise arrays without a functional reset value
  // should be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        code_q[i] <= CODE_BLANK;
      end
      dp_q <= '0;
    end else if (load) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        code_q[i] <= codes[5*i +: 5];
      end
      dp_q <= dp_mask;
    end
  end

  // Refresh counter and digit index; both hold while the display is off.
  assign tick = enable && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the
      // same pre-edge values, as real flops do.
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int               BCNT_W    = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_SLOTS - 1);

  logic [N_DIGITS-1:0] blink_q;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic                blank_now;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (tick) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      if (load) begin
        blink_q <= blink_mask;
      end
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  // Phase and index advance on the same tick, so they always agree here.
  assign blank_now = blink_q[idx_q] & phase_q;
`else
  localparam int unused_blink_slots = BLINK_SLOTS;
  logic unused_blink_mask;
  logic blank_now;

  assign unused_blink_mask = ^blink_mask;
  assign blank_now         = 1'b0;
`endif

  // Character decode to {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'd0:    pat = 7'b1111110;
      5'd1:    pat = 7'b0110000;
      5'd2:    pat = 7'b1101101;
      5'd3:    pat = 7'b1111001;
      5'd4:    pat = 7'b0110011;
      5'd5:    pat = 7'b1011011;
      5'd6:    pat = 7'b1011111;
      5'd7:    pat = 7'b1110000;
      5'd8:    pat = 7'b1111111;
      5'd9:    pat = 7'b1111011;
      5'd10:   pat = 7'b1110111;
      5'd11:   pat = 7'b0011111;
      5'd12:   pat = 7'b1001110;
      5'd13:   pat = 7'b0111101;
      5'd14:   pat = 7'b1001111;
      5'd15:   pat = 7'b1000111;
      5'd16:   pat = 7'b1110000;
      5'd17:   pat = 7'b0111000;
      5'd18:   pat = 7'b0000001;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  // Outputs follow the index one cycle later, from one coherent shadow read.
  always_comb begin
    an_d  = '1;
    seg_d = '0;
    if (enable) begin
      an_d = ~(N_DIGITS'(1) << idx_q);
      if (!blank_now) begin
        seg_d = {decode(code_q[idx_q]), dp_q[idx_q]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= '0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: scan order, decode, load timing, enable, reset, blink.
// Blink expectations follow whether SEG_SCAN_BLINK_EN is defined for the build.
module tb_seg_scan_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 4 digits, 4-cycle slots.
  logic        rst_n, enable, load;
  logic [19:0] codes;
  logic [3:0]  dp_mask, blink_mask;
  logic [7:0]  seg;
  logic [3:0]  an;

  // Blink instance: 3 digits so the blink period does not alias with the scan period.
  logic        b_rst_n, b_enable, b_load;
  logic [14:0] b_codes;
  logic [2:0]  b_dp_mask, b_blink_mask;
  logic [7:0]  b_seg;
  logic [2:0]  b_an;

  int checks   = 0;
  int failures = 0;
  int e        = 0;
  bit blink_on;

  localparam logic [7:0] SEG_D0    = 8'b11111101;
  localparam logic [7:0] SEG_D1    = 8'b11101110;
  localparam logic [7:0] SEG_D2    = 8'b11100000;
  localparam logic [7:0] SEG_D3    = 8'b01110000;
  localparam logic [7:0] SEG_DASH  = 8'b00000010;
  localparam logic [7:0] SEG_EIGHT = 8'b11111110;
  localparam logic [7:0] SEG_ONE   = 8'b01100000;
  localparam logic [7:0] SEG_ZERO  = 8'b11111100;

  logic [3:0] an_of  [4];
  logic [7:0] dec_of [4];

  seg_scan_display #(.N_DIGITS(4), .REFRESH_DIV(4), .BLINK_SLOTS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .codes(codes),
    .dp_mask(dp_mask), .blink_mask(blink_mask), .seg(seg), .an(an)
  );

  seg_scan_display #(.N_DIGITS(3), .REFRESH_DIV(2), .BLINK_SLOTS(2)) u_blk (
    .clk(clk), .rst_n(b_rst_n), .enable(b_enable), .load(b_load), .codes(b_codes),
    .dp_mask(b_dp_mask), .blink_mask(b_blink_mask), .seg(b_seg), .an(b_an)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; outputs then reflect the preceding rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      e++;
    end
  endtask

  initial begin
    logic [2:0] exp_an;
    logic [7:0] exp_seg;
    int         dig;

`ifdef SEG_SCAN_BLINK_EN
    blink_on = 1'b1;
`else
    blink_on = 1'b0;
`endif
    an_of  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    dec_of = '{SEG_D0, SEG_D1, SEG_D2, SEG_D3};

    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    codes = '0; dp_mask = '0; blink_mask = '0;
    b_rst_n = 1'b0; b_enable = 1'b0; b_load = 1'b0;
    b_codes = '0; b_dp_mask = '0; b_blink_mask = '0;

    // Reset state.
    cyc(2);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", seg, 8'h00);

    // Scan order after release: each digit held for 4 cycles.
    rst_n = 1'b1; enable = 1'b1; e = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      check("scan_an", {4'h0, an}, {4'h0, an_of[(k / 4) % 4]});
      check("scan_seg_blank", seg, 8'h00);
    end

    // Decode: codes {17,16,10,0}, dp on digit 0.
    codes = {5'd17, 5'd16, 5'd10, 5'd0}; dp_mask = 4'b0001; load = 1'b1;
    cyc(1);
    load = 1'b0; codes = '0; dp_mask = '0;
    check("load_prev_update", seg, 8'h00);
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      dig = ((e - 1) >> 2) & 3;
      check("dec_an", {4'h0, an}, {4'h0, an_of[dig]});
      check("dec_seg", seg, dec_of[dig]);
    end

    // Load on the slot-tick edge (edge 40): old pattern on that edge, new one right after.
    cyc(2);
    codes = {4{5'd18}}; dp_mask = 4'b0000; load = 1'b1;
    cyc(1);
    load = 1'b0; codes = '0;
    check("tick_load_an_old", {4'h0, an}, 8'b00001101);
    check("tick_load_seg_old", seg, SEG_D1);
    cyc(1);
    check("tick_load_an_new", {4'h0, an}, 8'b00001011);
    check("tick_load_seg_new", seg, SEG_DASH);
    cyc(1);
    check("tick_load_seg_hold", seg, SEG_DASH);

    // Enable low for 10 cycles, two cycles into digit 2's slot.
    enable = 1'b0;
    cyc(1);
    check("dis_an_first", {4'h0, an}, 8'h0F);
    check("dis_seg_first", seg, 8'h00);
    cyc(9);
    check("dis_an_last", {4'h0, an}, 8'h0F);
    check("dis_seg_last", seg, 8'h00);
    enable = 1'b1;
    cyc(1);
    check("resume_an_0", {4'h0, an}, 8'b00001011);
    check("resume_seg", seg, SEG_DASH);
    cyc(1);
    check("resume_an_1", {4'h0, an}, 8'b00001011);
    cyc(1);
    check("resume_next_an", {4'h0, an}, 8'b00000111);

    // Reset mid-slot: outputs clear without a clock edge, scan restarts at digit 0.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", {4'h0, an}, 8'h0F);
    check("async_rst_seg", seg, 8'h00);
    cyc(1);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("rst_restart_an", {4'h0, an}, {4'h0, (k < 4) ? 4'b1110 : 4'b1101});
      check("rst_restart_seg", seg, 8'h00);
    end

    // Blink: digit 1 = code 8 with blink, digits 0 and 2 steady.
    b_rst_n = 1'b1;
    b_codes = {5'd0, 5'd8, 5'd1}; b_dp_mask = 3'b000; b_blink_mask = 3'b010; b_load = 1'b1;
    cyc(1);
    b_load = 1'b0; b_codes = '0; b_blink_mask = '0; b_enable = 1'b1;
    for (int s = 0; s < 12; s++) begin
      for (int j = 0; j < 2; j++) begin
        cyc(1);
        case (s % 3)
          0: begin exp_an = 3'b110; exp_seg = SEG_ONE; end
          1: begin exp_an = 3'b101; exp_seg = (blink_on && s[1]) ? 8'h00 : SEG_EIGHT; end
          default: begin exp_an = 3'b011; exp_seg = SEG_ZERO; end
        endcase
        check("blink_an", {5'h0, b_an}, {5'h0, exp_an});
        check("blink_seg", b_seg, exp_seg);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
